// File: rtl/tick_sched.sv
// tick_sched: multi-channel reloadable tick counters arbitrated to one tick per cycle.
// Optional TICK_SCHED_ROUND_ROBIN_EN selects rotating priority instead of fixed.
module tick_sched #(
   parameter int NUM_CH = 2,
   parameter int CNT_W = 26,
   parameter logic [NUM_CH*CNT_W-1:0] RST_PERIOD = {26'd2_500_000, 26'd42_500_000},
   parameter int CH_W = (NUM_CH > 1 ? $clog2(NUM_CH) : 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ticking,
   input  logic              period_wr,
   input  logic [CH_W-1:0]   period_ch,
   input  logic [CNT_W-1:0]  period_data,
   input  logic [NUM_CH-1:0] restart,
   input  logic              clr_overrun,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] pending,
   output logic [NUM_CH-1:0] overrun
);
   logic [CNT_W-1:0]  period [NUM_CH];
   logic [CNT_W-1:0]  cnt [NUM_CH];
   logic [NUM_CH-1:0] wr_hit, expd, req, gnt;
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         wr_hit[i] = period_wr && int'(period_ch) == i;
         expd[i] = ticking && !wr_hit[i] && !restart[i] &&
                   cnt[i] == ((period[i] == '0) ? '0 : period[i] - CNT_W'(1));
      end
      req = ticking ? (pending | expd) & ~restart : '0;
   end
`ifdef TICK_SCHED_ROUND_ROBIN_EN
   logic [CH_W-1:0] last_gnt, gnt_idx, j;
   // search begins one past the previous winner and wraps around
   always_comb begin
      gnt = '0;
      gnt_idx = last_gnt;
      j = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         j = CH_W'((int'(last_gnt) + k) % NUM_CH);
         if (gnt == '0 && req[j]) begin
            gnt[j] = 1'b1;
            gnt_idx = j;
         end
      end
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) last_gnt <= CH_W'(NUM_CH - 1);
      else if (|gnt) last_gnt <= gnt_idx;
`else
   assign gnt = req & (~req + NUM_CH'(1));
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         tick <= '0;
         pending <= '0;
         overrun <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt[i] <= '0;
            period[i] <= RST_PERIOD[i*CNT_W +: CNT_W];
         end
      end else begin
         tick <= gnt;
         pending <= (ticking ? req & ~gnt : pending) & ~restart;
         overrun <= (clr_overrun ? '0 : overrun) | (expd & pending);
         for (int i = 0; i < NUM_CH; i++) begin
            if (wr_hit[i]) period[i] <= period_data;
            if (wr_hit[i] || restart[i] || expd[i]) cnt[i] <= '0;
            else if (ticking) cnt[i] <= cnt[i] + CNT_W'(1);
         end
      end
endmodule

// File: tb/tb_tick_sched.sv
// tb_tick_sched: table-driven checks of tick_sched with periods 6 (ch0) and 4 (ch1).
// Expectations for the collision run follow TICK_SCHED_ROUND_ROBIN_EN when defined.
module tb_tick_sched;
   typedef struct {
      logic t, wr, ch;
      logic [7:0] d;
      logic [1:0] rs;
      logic clr;
      logic [1:0] tk, pd, ov;
   } vec_t;
   logic clk = 0, rst = 0, ticking = 0, period_wr = 0, clr_overrun = 0;
   logic [0:0] period_ch = '0;
   logic [7:0] period_data = '0;
   logic [1:0] restart = '0, tick, pending, overrun;
   int checks = 0, errors = 0;
   vec_t seq[$];
   logic [5:0] exp_q[$];
   logic [1:0] t1[16] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2,
                          2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd2};
`ifdef TICK_SCHED_ROUND_ROBIN_EN
   logic [1:0] ct[9] = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd2};
   logic [1:0] cp[9] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1};
   logic [1:0] co[9] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
`else
   logic [1:0] ct[9] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
   logic [1:0] cp[9] = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
   logic [1:0] co[9] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd0, 2'd2};
`endif
   tick_sched #(.NUM_CH(2), .CNT_W(8), .RST_PERIOD({8'd4, 8'd6})) dut (
      .clk(clk), .rst(rst), .ticking(ticking), .period_wr(period_wr),
      .period_ch(period_ch), .period_data(period_data), .restart(restart),
      .clr_overrun(clr_overrun), .tick(tick), .pending(pending), .overrun(overrun)
   );
   always #5 clk = ~clk;
   function automatic vec_t V(logic t, logic wr, logic ch, logic [7:0] d, logic [1:0] rs,
                              logic clr, logic [1:0] tk, logic [1:0] pd, logic [1:0] ov);
      vec_t r;
      r = '{t, wr, ch, d, rs, clr, tk, pd, ov};
      return r;
   endfunction
   task automatic run(input string name);
      logic [5:0] got, want;
      for (int i = 0; i < seq.size(); i++) begin
         ticking = seq[i].t;
         period_wr = seq[i].wr;
         period_ch = seq[i].ch;
         period_data = seq[i].d;
         restart = seq[i].rs;
         clr_overrun = seq[i].clr;
         exp_q.push_back({seq[i].tk, seq[i].pd, seq[i].ov});
         @(posedge clk);
         @(negedge clk);
         got = {tick, pending, overrun};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL %s[%0d]: tick/pending/overrun got %b/%b/%b want %b/%b/%b", name, i + 1,
                     got[5:4], got[3:2], got[1:0], want[5:4], want[3:2], want[1:0]);
         end
      end
      seq.delete();
   endtask
   task automatic reset_check(input string name);
      @(negedge clk);
      #2 rst = 1;
      {ticking, period_wr, clr_overrun, restart} = '0;
      #1 checks++;
      if ({tick, pending, overrun} !== 6'b0) begin
         errors++;
         $display("FAIL %s: tick/pending/overrun got %b/%b/%b want 00/00/00", name,
                  tick, pending, overrun);
      end
      @(negedge clk);
      rst = 0;
   endtask
   task automatic load_t1(input int n);
      for (int i = 0; i < n; i++)
         seq.push_back(V(1, 0, 0, 0, 0, 0, t1[i], i == 11 ? 2'b10 : 2'b00, 0));
   endtask
   initial begin
      reset_check("reset");
      load_t1(16);
      run("periods_6_4");
      reset_check("reset_pause");
      for (int i = 0; i < 3; i++) seq.push_back(V(1, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 10; i++) seq.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0));
      seq.push_back(V(1, 0, 0, 0, 0, 0, 2'b10, 0, 0));
      seq.push_back(V(1, 0, 0, 0, 0, 0, 2'b00, 0, 0));
      seq.push_back(V(1, 0, 0, 0, 0, 0, 2'b01, 0, 0));
      seq.push_back(V(1, 0, 0, 0, 0, 0, 2'b00, 0, 0));
      seq.push_back(V(1, 0, 0, 0, 0, 0, 2'b10, 0, 0));
      run("pause");
      reset_check("reset_wr");
      seq.push_back(V(1, 0, 0, 0, 0, 0, 0, 0, 0));
      seq.push_back(V(1, 0, 0, 0, 0, 0, 0, 0, 0));
      seq.push_back(V(1, 1, 0, 0, 0, 0, 0, 0, 0));
      seq.push_back(V(1, 0, 0, 0, 0, 0, 2'b01, 2'b10, 0));
      seq.push_back(V(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0));
      run("period_zero");
      reset_check("reset_restart");
      load_t1(12);
      seq.push_back(V(0, 0, 0, 0, 0, 0, 0, 2'b10, 0));
      seq.push_back(V(0, 1, 0, 1, 0, 0, 0, 2'b10, 0));
      seq.push_back(V(0, 1, 1, 1, 0, 0, 0, 2'b10, 0));
      seq.push_back(V(1, 0, 0, 0, 2'b10, 0, 2'b01, 0, 0));
      seq.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0));
      run("restart");
      reset_check("reset_collide");
      seq.push_back(V(0, 1, 0, 1, 0, 0, 0, 0, 0));
      seq.push_back(V(0, 1, 1, 3, 0, 0, 0, 0, 0));
      for (int i = 0; i < 9; i++) seq.push_back(V(1, 0, 0, 0, 0, i == 7, ct[i], cp[i], co[i]));
      run("collision");
      reset_check("async_rst_busy");
      load_t1(6);
      run("after_rst");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
